// File: rtl/traffic_phase_scheduler.sv
// ----------------------------------------------------------------------------
// Module   : traffic_phase_scheduler
// Function : Actuated NS/EW/walk phase sequencer with min/max green timing.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module traffic_phase_scheduler #(
  parameter int unsigned MIN_G = 4,
  parameter int unsigned MAX_G = 10,
  parameter int unsigned YEL   = 2,
  parameter int unsigned CLR   = 1,
  parameter int unsigned WALK  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_btn,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [2:0] ST_NS_G   = 3'd0;
  localparam logic [2:0] ST_NS_Y   = 3'd1;
  localparam logic [2:0] ST_NS_CLR = 3'd2;
  localparam logic [2:0] ST_EW_G   = 3'd3;
  localparam logic [2:0] ST_EW_Y   = 3'd4;
  localparam logic [2:0] ST_EW_CLR = 3'd5;
  localparam logic [2:0] ST_WALK   = 3'd6;

  localparam logic [8:0] C_MIN_G = 9'(MIN_G);
  localparam logic [8:0] C_MAX_G = 9'(MAX_G);
  localparam logic [8:0] C_YEL   = 9'(YEL);
  localparam logic [8:0] C_CLR   = 9'(CLR);
  localparam logic [8:0] C_WALK  = 9'(WALK);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ped_q, ped_d;
  logic       last_dir_q, last_dir_d;

  logic [2:0] nxt;
  logic [8:0] n;

  // n counts the ticks spent in the phase including the one being applied now
  assign n = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    nxt        = state_q;
    last_dir_d = last_dir_q;
    case (state_q)
      ST_NS_G: begin
        if (n >= C_MIN_G && (ew_car || ped_q) && (!ns_car || n >= C_MAX_G))
          nxt = ST_NS_Y;
      end
      ST_NS_Y: begin
        if (n == C_YEL) nxt = ST_NS_CLR;
      end
      ST_NS_CLR: begin
        if (n == C_CLR) begin
          if (ped_q) begin
            nxt        = ST_WALK;
            last_dir_d = 1'b0;
          end else begin
            nxt = ST_EW_G;
          end
        end
      end
      ST_EW_G: begin
        if (n >= C_MIN_G && (ns_car || ped_q) && (!ew_car || n >= C_MAX_G))
          nxt = ST_EW_Y;
      end
      ST_EW_Y: begin
        if (n == C_YEL) nxt = ST_EW_CLR;
      end
      ST_EW_CLR: begin
        if (n == C_CLR) begin
          if (ped_q) begin
            nxt        = ST_WALK;
            last_dir_d = 1'b1;
          end else begin
            nxt = ST_NS_G;
          end
        end
      end
      ST_WALK: begin
        if (n == C_WALK) nxt = last_dir_q ? ST_NS_G : ST_EW_G;
      end
      default: nxt = ST_NS_CLR;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ped_d   = ped_q | ped_btn;
    if (state_q == 3'd7) begin
      // illegal code recovers through clearance without waiting for a tick
      state_d = ST_NS_CLR;
      cnt_d   = 8'd0;
    end else if (tick) begin
      state_d = nxt;
      if (nxt != state_q) begin
        cnt_d = 8'd0;
      end else if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
      if (nxt == ST_WALK && state_q != ST_WALK) ped_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_NS_G;
      cnt_q      <= 8'd0;
      ped_q      <= 1'b0;
      last_dir_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_q      <= ped_d;
      last_dir_q <= (state_q == 3'd7 || !tick) ? last_dir_q : last_dir_d;
    end
  end

  always_comb begin
    ns_g = 1'b0;
    ns_y = 1'b0;
    ns_r = 1'b1;
    ew_g = 1'b0;
    ew_y = 1'b0;
    ew_r = 1'b1;
    walk = 1'b0;
    case (state_q)
      ST_NS_G: begin ns_g = 1'b1; ns_r = 1'b0; end
      ST_NS_Y: begin ns_y = 1'b1; ns_r = 1'b0; end
      ST_EW_G: begin ew_g = 1'b1; ew_r = 1'b0; end
      ST_EW_Y: begin ew_y = 1'b1; ew_r = 1'b0; end
      ST_WALK: walk = 1'b1;
      default: ;
    endcase
  end

  assign ped_pending = ped_q;
  assign phase       = state_q;

endmodule

`default_nettype wire
